// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard/forwarding controller.
//   DEF_REG_ADDR_W : default register-specifier width
//   FWD_*          : forwarding mux select encodings (regfile/EX/MEM/WB)
//   haz_state_e    : load-use stall FSM states
package hazard_fwd_ctrl_pkg;

    localparam int DEF_REG_ADDR_W = 3;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef enum logic {
        RUN     = 1'b0,
        LD_WAIT = 1'b1
    } haz_state_e;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_match.sv
// Per-source forwarding comparator.
// Compares one ID source specifier against the EX/MEM/WB destinations and
// picks the youngest writer (EX > MEM > WB > regfile).
//   rs_i, src_used_i            : source specifier and its "actually read" qualifier
//   rd_*_i, *_reg_wr_i          : destination specifier / write enable per stage
//   fwd_sel_o                   : forwarding mux select for this source
//   ex_hit_o                    : source is produced by the EX-stage instruction
module fwd_match
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic                  src_used_i,
    input  logic [REG_ADDR_W-1:0] rd_ex_i,
    input  logic [REG_ADDR_W-1:0] rd_mem_i,
    input  logic [REG_ADDR_W-1:0] rd_wb_i,
    input  logic                  ex_reg_wr_i,
    input  logic                  mem_reg_wr_i,
    input  logic                  wb_reg_wr_i,
    output logic [1:0]            fwd_sel_o,
    output logic                  ex_hit_o
);

    logic cmp_en;
    logic hit_ex;
    logic hit_mem;
    logic hit_wb;

    // Register 0 is hardwired zero when ZERO_REG_EN, so it never forwards.
    assign cmp_en  = src_used_i && ((rs_i != '0) || !ZERO_REG_EN);
    assign hit_ex  = cmp_en && ex_reg_wr_i  && (rs_i == rd_ex_i);
    assign hit_mem = cmp_en && mem_reg_wr_i && (rs_i == rd_mem_i);
    assign hit_wb  = cmp_en && wb_reg_wr_i  && (rs_i == rd_wb_i);

    always_comb begin
        fwd_sel_o = FWD_RF;
        if (hit_ex) begin
            fwd_sel_o = FWD_EX;
        end else if (hit_mem) begin
            fwd_sel_o = FWD_MEM;
        end else if (hit_wb) begin
            fwd_sel_o = FWD_WB;
        end
    end

    assign ex_hit_o = hit_ex;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Decode-stage hazard and forwarding controller.
// Drives PC/IF-ID hold (stall), ID/EX bubble insertion (bubble), global
// pipeline freeze on data-memory busy (freeze), IF/ID flush (flush_if) and
// the per-source forwarding mux selects (fwd_sel, 2 bits per source).
//   clk, reset      : clock, synchronous active-high reset
//   rs, src_used    : ID source specifiers (packed per source) and qualifiers
//   rd_*, *_reg_wr  : EX/MEM/WB destination specifiers and write enables
//   ex_mem_rd       : EX instruction is a load
//   mem_busy        : data memory not ready
//   kill_in         : ID resolved a taken control transfer
// Optional build macro HAZ_PERF_CNT_EN adds saturating performance counters
// perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt (cleared by reset).
//
// state   | meaning
// RUN     | normal issue; a load-use hazard stalls for one cycle here
// LD_WAIT | remaining load-use stall cycles, counted down in cnt
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int NUM_SRC     = 2,
    parameter int LOAD_LAT    = 1,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] rs,
    input  logic [NUM_SRC-1:0]            src_used,
    input  logic [REG_ADDR_W-1:0]         rd_ex,
    input  logic [REG_ADDR_W-1:0]         rd_mem,
    input  logic [REG_ADDR_W-1:0]         rd_wb,
    input  logic                          ex_reg_wr,
    input  logic                          mem_reg_wr,
    input  logic                          wb_reg_wr,
    input  logic                          ex_mem_rd,
    input  logic                          mem_busy,
    input  logic                          kill_in,
    output logic [2*NUM_SRC-1:0]          fwd_sel,
    output logic                          stall,
    output logic                          bubble,
    output logic                          freeze,
    output logic                          flush_if
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_stall_cnt,
    output logic [31:0]                   perf_flush_cnt,
    output logic [31:0]                   perf_freeze_cnt
`endif
);

    localparam logic [3:0] LAT_M1    = 4'(LOAD_LAT - 1);
    localparam bit         MULTI_CYC = (LOAD_LAT > 1);

    logic [NUM_SRC-1:0] ex_hit;
    logic               luse;
    logic               stall_c;

    haz_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_match #(
            .REG_ADDR_W (REG_ADDR_W),
            .ZERO_REG_EN(ZERO_REG_EN)
        ) u_fwd_match (
            .rs_i        (rs[g*REG_ADDR_W +: REG_ADDR_W]),
            .src_used_i  (src_used[g]),
            .rd_ex_i     (rd_ex),
            .rd_mem_i    (rd_mem),
            .rd_wb_i     (rd_wb),
            .ex_reg_wr_i (ex_reg_wr),
            .mem_reg_wr_i(mem_reg_wr),
            .wb_reg_wr_i (wb_reg_wr),
            .fwd_sel_o   (fwd_sel[2*g +: 2]),
            .ex_hit_o    (ex_hit[g])
        );
    end

    // ex_hit already implies ex_reg_wr; kept explicit to mirror the hazard rule.
    assign luse   = ex_mem_rd && ex_reg_wr && (|ex_hit);
    assign freeze = mem_busy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        unique case (state_q)
            RUN: begin
                stall_c = luse && !freeze;
                if (stall_c && MULTI_CYC) begin
                    state_d = LD_WAIT;
                    cnt_d   = LAT_M1;
                end
            end
            LD_WAIT: begin
                // Comparators are ignored: the load is already in flight.
                stall_c = !freeze;
                if (!freeze) begin
                    if (cnt_q == 4'd1) begin
                        state_d = RUN;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall    = stall_c;
    assign bubble   = stall_c;
    // A branch waiting on its operands must not redirect fetch yet.
    assign flush_if = kill_in && !stall_c && !freeze;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_flush_q, perf_freeze_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q  <= '0;
            perf_flush_q  <= '0;
            perf_freeze_q <= '0;
        end else begin
            if (stall_c && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (flush_if && (perf_flush_q != '1)) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
            if (freeze && (perf_freeze_q != '1)) begin
                perf_freeze_q <= perf_freeze_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt  = perf_stall_q;
    assign perf_flush_cnt  = perf_flush_q;
    assign perf_freeze_cnt = perf_freeze_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: three instances (LOAD_LAT = 1, 3, 4) share the
// pipeline inputs but have separate resets, so idle instances are parked in
// reset. Directed vectors push expected outputs into a queue; a monitor on
// the falling edge pops and compares against the addressed instance.
module tb_hazard_fwd_ctrl;

    typedef struct {
        int         dut;
        logic       stall;
        logic       bubble;
        logic       freeze;
        logic       flush;
        logic [3:0] fwd;
        logic       perf_chk;
        int         p_stall;
        int         p_flush;
        int         p_freeze;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic       clk = 1'b0;
    logic [2:0] rst;
    logic [5:0] rs;
    logic [1:0] src_used;
    logic [2:0] rd_ex, rd_mem, rd_wb;
    logic       ex_reg_wr, mem_reg_wr, wb_reg_wr, ex_mem_rd, mem_busy, kill_in;

    logic [3:0] fwd_w    [3];
    logic       stall_w  [3];
    logic       bubble_w [3];
    logic       freeze_w [3];
    logic       flush_w  [3];
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] pst_w [3];
    logic [31:0] pfl_w [3];
    logic [31:0] pfz_w [3];
`endif

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.REG_ADDR_W(3), .NUM_SRC(2), .LOAD_LAT(1), .ZERO_REG_EN(1'b1)) u_lat1 (
        .clk(clk), .reset(rst[0]), .rs(rs), .src_used(src_used),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .ex_reg_wr(ex_reg_wr), .mem_reg_wr(mem_reg_wr), .wb_reg_wr(wb_reg_wr),
        .ex_mem_rd(ex_mem_rd), .mem_busy(mem_busy), .kill_in(kill_in),
        .fwd_sel(fwd_w[0]), .stall(stall_w[0]), .bubble(bubble_w[0]),
        .freeze(freeze_w[0]), .flush_if(flush_w[0])
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall_cnt(pst_w[0]), .perf_flush_cnt(pfl_w[0]), .perf_freeze_cnt(pfz_w[0])
`endif
    );

    hazard_fwd_ctrl #(.REG_ADDR_W(3), .NUM_SRC(2), .LOAD_LAT(3), .ZERO_REG_EN(1'b1)) u_lat3 (
        .clk(clk), .reset(rst[1]), .rs(rs), .src_used(src_used),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .ex_reg_wr(ex_reg_wr), .mem_reg_wr(mem_reg_wr), .wb_reg_wr(wb_reg_wr),
        .ex_mem_rd(ex_mem_rd), .mem_busy(mem_busy), .kill_in(kill_in),
        .fwd_sel(fwd_w[1]), .stall(stall_w[1]), .bubble(bubble_w[1]),
        .freeze(freeze_w[1]), .flush_if(flush_w[1])
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall_cnt(pst_w[1]), .perf_flush_cnt(pfl_w[1]), .perf_freeze_cnt(pfz_w[1])
`endif
    );

    hazard_fwd_ctrl #(.REG_ADDR_W(3), .NUM_SRC(2), .LOAD_LAT(4), .ZERO_REG_EN(1'b1)) u_lat4 (
        .clk(clk), .reset(rst[2]), .rs(rs), .src_used(src_used),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .ex_reg_wr(ex_reg_wr), .mem_reg_wr(mem_reg_wr), .wb_reg_wr(wb_reg_wr),
        .ex_mem_rd(ex_mem_rd), .mem_busy(mem_busy), .kill_in(kill_in),
        .fwd_sel(fwd_w[2]), .stall(stall_w[2]), .bubble(bubble_w[2]),
        .freeze(freeze_w[2]), .flush_if(flush_w[2])
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall_cnt(pst_w[2]), .perf_flush_cnt(pfl_w[2]), .perf_freeze_cnt(pfz_w[2])
`endif
    );

    task automatic drv(input logic [2:0] r0, input logic [2:0] r1, input logic [1:0] used,
                       input logic [2:0] re, input logic [2:0] rm, input logic [2:0] rw,
                       input logic ew, input logic mw, input logic ww,
                       input logic ld, input logic busy, input logic kill);
        rs         = {r1, r0};
        src_used   = used;
        rd_ex      = re;
        rd_mem     = rm;
        rd_wb      = rw;
        ex_reg_wr  = ew;
        mem_reg_wr = mw;
        wb_reg_wr  = ww;
        ex_mem_rd  = ld;
        mem_busy   = busy;
        kill_in    = kill;
    endtask

    task automatic expp(input int d, input logic s, input logic b, input logic f, input logic fl,
                        input logic [3:0] fw, input logic pc, input int ps, input int pf,
                        input int pz, input string nm);
        exp_t e;
        e.dut = d; e.stall = s; e.bubble = b; e.freeze = f; e.flush = fl; e.fwd = fw;
        e.perf_chk = pc; e.p_stall = ps; e.p_flush = pf; e.p_freeze = pz; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic expc(input int d, input logic s, input logic b, input logic f, input logic fl,
                        input logic [3:0] fw, input string nm);
        expp(d, s, b, f, fl, fw, 1'b0, 0, 0, 0, nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drv(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // hazard: EX load writes r3, ID source 0 reads r3
    task automatic haz(input logic busy, input logic kill);
        drv(3, 0, 2'b01, 3, 0, 0, 1, 0, 0, 1, busy, kill);
    endtask

    // load has moved to MEM; EX holds a bubble
    task automatic post(input logic busy, input logic kill);
        drv(3, 0, 2'b01, 0, 3, 0, 0, 1, 0, 0, busy, kill);
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic ok;
            e  = exp_q.pop_front();
            ok = (stall_w[e.dut] === e.stall) && (bubble_w[e.dut] === e.bubble) &&
                 (freeze_w[e.dut] === e.freeze) && (flush_w[e.dut] === e.flush) &&
                 (fwd_w[e.dut] === e.fwd);
`ifdef HAZ_PERF_CNT_EN
            if (e.perf_chk) begin
                ok = ok && (pst_w[e.dut] === 32'(e.p_stall)) && (pfl_w[e.dut] === 32'(e.p_flush)) &&
                     (pfz_w[e.dut] === 32'(e.p_freeze));
                if (!ok) begin
                    $display("FAIL %s perf: got stall=%0d flush=%0d freeze=%0d want %0d %0d %0d",
                             e.name, pst_w[e.dut], pfl_w[e.dut], pfz_w[e.dut],
                             e.p_stall, e.p_flush, e.p_freeze);
                end
            end
`endif
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s dut%0d: got stall=%b bubble=%b freeze=%b flush=%b fwd=%b want %b %b %b %b %b",
                         e.name, e.dut, stall_w[e.dut], bubble_w[e.dut], freeze_w[e.dut],
                         flush_w[e.dut], fwd_w[e.dut], e.stall, e.bubble, e.freeze, e.flush, e.fwd);
            end
        end
    end

    initial begin
        rst = 3'b111;
        idle();
        tick();

        // reset state
        rst = 3'b110;
        idle();
        for (int d = 0; d < 3; d++) expp(d, 0, 0, 0, 0, 4'b0000, 1'b1, 0, 0, 0, "reset_state");
        tick();

        // single-cycle load-use
        haz(0, 0);  expc(0, 1, 1, 0, 0, 4'b0001, "luse_lat1");        tick();
        post(0, 0); expc(0, 0, 0, 0, 0, 4'b0010, "after_luse_lat1");  tick();

        // multi-cycle load-use with freeze inside LD_WAIT
        rst = 3'b101;
        haz(0, 0);  expc(1, 1, 1, 0, 0, 4'b0001, "lat3_stall1");      tick();
        post(1, 0); expc(1, 0, 0, 1, 0, 4'b0010, "lat3_busy1");       tick();
        post(1, 0); expc(1, 0, 0, 1, 0, 4'b0010, "lat3_busy2");       tick();
        post(0, 0); expc(1, 1, 1, 0, 0, 4'b0010, "lat3_stall2");      tick();
        post(0, 1); expc(1, 1, 1, 0, 0, 4'b0010, "lat3_stall3_kill"); tick();
        post(0, 1); expc(1, 0, 0, 0, 1, 4'b0010, "lat3_done_flush");  tick();

        // kill gating on the single-cycle instance
        rst = 3'b110;
        haz(0, 1);  expc(0, 1, 1, 0, 0, 4'b0001, "kill_with_luse");   tick();
        post(0, 1); expc(0, 0, 0, 0, 1, 4'b0010, "kill_flush");       tick();

        // forwarding priority and qualifiers
        drv(0, 5, 2'b10, 5, 5, 5, 1, 1, 1, 0, 0, 0); expc(0, 0, 0, 0, 0, 4'b0100, "prio_ex");    tick();
        drv(0, 5, 2'b00, 5, 5, 5, 1, 1, 1, 0, 0, 0); expc(0, 0, 0, 0, 0, 4'b0000, "src_unused"); tick();
        drv(0, 0, 2'b11, 0, 0, 0, 1, 1, 1, 0, 0, 0); expc(0, 0, 0, 0, 0, 4'b0000, "zero_reg");   tick();
        drv(0, 5, 2'b10, 4, 5, 5, 1, 1, 1, 0, 0, 0); expc(0, 0, 0, 0, 0, 4'b1000, "prio_mem");   tick();
        drv(6, 5, 2'b11, 6, 4, 5, 1, 1, 1, 0, 0, 0); expc(0, 0, 0, 0, 0, 4'b1101, "ex_and_wb");  tick();
        drv(6, 5, 2'b11, 6, 6, 5, 0, 1, 1, 0, 0, 0); expc(0, 0, 0, 0, 0, 4'b1110, "ex_wr_off");  tick();
        drv(0, 0, 2'b01, 0, 0, 0, 1, 0, 0, 1, 0, 0); expc(0, 0, 0, 0, 0, 4'b0000, "load_r0");    tick();
        haz(1, 1);  expc(0, 0, 0, 1, 0, 4'b0001, "freeze_override");  tick();

        // reset aborts LD_WAIT
        rst = 3'b011;
        haz(0, 0);  expc(2, 1, 1, 0, 0, 4'b0001, "lat4_stall1");      tick();
        rst = 3'b111;
        post(0, 0); expc(2, 1, 1, 0, 0, 4'b0010, "lat4_stall2");      tick();
        rst = 3'b011;
        post(0, 0); expc(2, 0, 0, 0, 0, 4'b0010, "rst_abort");        tick();
        post(0, 0); expc(2, 0, 0, 0, 0, 4'b0010, "rst_abort_hold");   tick();

        // counter activity: 3 stall, 2 flush, 4 freeze cycles
        rst = 3'b111;
        idle(); tick();
        rst = 3'b110;
        haz(0, 0); expp(0, 1, 1, 0, 0, 4'b0001, 1'b1, 0, 0, 0, "perf_cleared"); tick();
        haz(0, 0); tick();
        haz(0, 0); tick();
        drv(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        drv(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            tick();
        end
        idle(); expp(0, 0, 0, 0, 0, 4'b0000, 1'b1, 3, 2, 4, "perf_counts"); tick();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
